// File: rtl/can_packet_dispatcher.sv
// can_packet_dispatcher
//   Moves host packets to NUM_NODES CAN controllers and gathers their received
//   packets back into one stream.
//   - Input side: IN_DEPTH FIFO. Each non-empty cycle, one requesting node is
//     granted round-robin. The grant loads the FIFO head and the node's
//     programmed ID into that node's tx registers.
//   - Retransmit: each failed attempt forces tx_id to 0 (highest CAN priority).
//     After MAX_RETRY retries the packet is dropped and counted.
//   - rx_id pairs every node with a partner node's tx_id (neighbour or ring).
//   - Output side: one pending register per node. These are drained
//     round-robin into an OUT_DEPTH FIFO. Overwriting an undrained pending
//     packet counts as a loss.
// Ports:
//   clock, reset               clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_id      ID table write
//   in_valid/in_ready/in_data  host packet input handshake
//   data_in_req, retransmit    per-node load request / failed-transmit report
//   tx_valid/tx_packet/tx_id   per-node loaded packet and transmit ID
//   rx_id                      per-node expected receive ID
//   data_out_req/rx_packet     per-node received packet strobe and data
//   out_valid/out_ready/out_data/out_node  collected packet output handshake
//   lost_count, drop_count     saturating loss / drop counters
module can_packet_dispatcher #(
    parameter int NUM_NODES = 4,
    parameter int DATA_SIZE = 64,
    parameter int ID_SIZE   = 11,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int MAX_RETRY = 3,
    parameter int PAIR_MODE = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_NODES)-1:0]   cfg_idx,
    input  logic [ID_SIZE-1:0]             cfg_id,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_SIZE-1:0]           in_data,
    input  logic [NUM_NODES-1:0]           data_in_req,
    input  logic [NUM_NODES-1:0]           retransmit,
    output logic [NUM_NODES-1:0]           tx_valid,
    output logic [NUM_NODES*DATA_SIZE-1:0] tx_packet,
    output logic [NUM_NODES*ID_SIZE-1:0]   tx_id,
    output logic [NUM_NODES*ID_SIZE-1:0]   rx_id,
    input  logic [NUM_NODES-1:0]           data_out_req,
    input  logic [NUM_NODES*DATA_SIZE-1:0] rx_packet,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_SIZE-1:0]           out_data,
    output logic [$clog2(NUM_NODES)-1:0]   out_node,
    output logic [15:0]                    lost_count,
    output logic [15:0]                    drop_count
);

    localparam int unsigned NW  = $clog2(NUM_NODES);
    localparam int unsigned IAW = $clog2(IN_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);
    localparam int unsigned RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Round-robin successor; works for non-power-of-two node counts too.
    function automatic logic [NW-1:0] next_ptr(input logic [NW-1:0] p);
        return NW'((int'(p) + 1) % NUM_NODES);
    endfunction

    // Adds several events in one cycle and clamps at 16'hFFFF.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input int unsigned b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Input FIFO. The extra pointer bit tells full apart from empty.
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] in_mem [IN_DEPTH];
    logic [IAW:0]         in_wr_ptr;
    logic [IAW:0]         in_rd_ptr;
    logic                 in_empty;
    logic                 in_full;
    logic                 in_push;
    logic                 grant_hit;
    logic [NW-1:0]        grant_idx;
    logic [NW-1:0]        grant_cand;
    logic [NW-1:0]        rr_in_ptr;
    logic [NUM_NODES-1:0] eligible;

    assign in_empty = (in_wr_ptr == in_rd_ptr);
    assign in_full  = (in_wr_ptr[IAW] != in_rd_ptr[IAW]) &&
                      (in_wr_ptr[IAW-1:0] == in_rd_ptr[IAW-1:0]);
    assign in_ready = !in_full;
    assign in_push  = in_valid && !in_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
        end else begin
            if (in_push) begin
                in_mem[in_wr_ptr[IAW-1:0]] <= in_data;
                in_wr_ptr                  <= in_wr_ptr + 1'b1;
            end
            if (grant_hit) begin
                in_rd_ptr <= in_rd_ptr + 1'b1;
            end
        end
    end

    // A node reporting a failed transmission is not eligible for a new packet.
    assign eligible = data_in_req & ~retransmit;

    // First eligible node at or after rr_in_ptr. Only the registered FIFO
    // state is used, so there is no bypass from in_data.
    always_comb begin
        grant_hit  = 1'b0;
        grant_idx  = '0;
        grant_cand = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            grant_cand = NW'((int'(rr_in_ptr) + k) % NUM_NODES);
            if (!in_empty && !grant_hit && eligible[grant_cand]) begin
                grant_hit = 1'b1;
                grant_idx = grant_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-node transmit state, ID table and retry handling
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] tx_pkt_q [NUM_NODES];
    logic [ID_SIZE-1:0]   tx_id_q  [NUM_NODES];
    logic [ID_SIZE-1:0]   id_table [NUM_NODES];
    logic [RW-1:0]        retry_q  [NUM_NODES];
    logic [NUM_NODES-1:0] drop_evt;

    // Retry budget exhausted: this retransmit drops the packet.
    always_comb begin
        drop_evt = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            drop_evt[i] = retransmit[i] && tx_valid[i] && (retry_q[i] >= RW'(MAX_RETRY));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_valid   <= '0;
            rr_in_ptr  <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                tx_pkt_q[i] <= '0;
                tx_id_q[i]  <= '0;
                id_table[i] <= '0;
                retry_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (retransmit[i] && tx_valid[i]) begin
                    if (drop_evt[i]) begin
                        tx_valid[i] <= 1'b0;
                        retry_q[i]  <= '0;
                    end else begin
                        retry_q[i] <= retry_q[i] + 1'b1;
                        tx_id_q[i] <= '0;
                    end
                end
            end
            // The grant never targets a retransmitting node, so it cannot
            // collide with the retry update above.
            if (grant_hit) begin
                tx_pkt_q[grant_idx] <= in_mem[in_rd_ptr[IAW-1:0]];
                tx_id_q[grant_idx]  <= id_table[grant_idx];
                tx_valid[grant_idx] <= 1'b1;
                retry_q[grant_idx]  <= '0;
                rr_in_ptr           <= next_ptr(grant_idx);
            end
            // The grant above reads the table before this write lands.
            if (cfg_we) begin
                id_table[cfg_idx] <= cfg_id;
            end
            drop_count <= sat_add(drop_count, $countones(drop_evt));
        end
    end

    // Flatten per-node registers and pair receive IDs.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
        localparam int PARTNER = (PAIR_MODE != 0) ? ((g + NUM_NODES - 1) % NUM_NODES)
                                                  : (((g ^ 1) < NUM_NODES) ? (g ^ 1) : g);
        assign tx_packet[g*DATA_SIZE +: DATA_SIZE] = tx_pkt_q[g];
        assign tx_id[g*ID_SIZE +: ID_SIZE]         = tx_id_q[g];
        assign rx_id[g*ID_SIZE +: ID_SIZE]         = tx_id_q[PARTNER];
    end

    // ------------------------------------------------------------------
    // Receive collection: pending registers drained round-robin
    // ------------------------------------------------------------------
    logic [NUM_NODES-1:0] pend;
    logic [DATA_SIZE-1:0] pend_data [NUM_NODES];
    logic [NW-1:0]        rr_out_ptr;
    logic                 drain_hit;
    logic [NW-1:0]        drain_idx;
    logic [NW-1:0]        drain_cand;
    logic [NUM_NODES-1:0] lost_evt;
    logic                 out_empty;
    logic                 out_full;

    always_comb begin
        drain_hit  = 1'b0;
        drain_idx  = '0;
        drain_cand = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            drain_cand = NW'((int'(rr_out_ptr) + k) % NUM_NODES);
            if (!out_full && !drain_hit && pend[drain_cand]) begin
                drain_hit = 1'b1;
                drain_idx = drain_cand;
            end
        end
    end

    // New data over an undrained pending packet loses the old packet.
    always_comb begin
        lost_evt = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            lost_evt[i] = data_out_req[i] && pend[i] && !(drain_hit && (drain_idx == NW'(i)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend       <= '0;
            rr_out_ptr <= '0;
            lost_count <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                pend_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (data_out_req[i]) begin
                    pend_data[i] <= rx_packet[i*DATA_SIZE +: DATA_SIZE];
                    pend[i]      <= 1'b1;
                end else if (drain_hit && (drain_idx == NW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
            if (drain_hit) begin
                rr_out_ptr <= next_ptr(drain_idx);
            end
            lost_count <= sat_add(lost_count, $countones(lost_evt));
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] out_mem      [OUT_DEPTH];
    logic [NW-1:0]        out_node_mem [OUT_DEPTH];
    logic [OAW:0]         out_wr_ptr;
    logic [OAW:0]         out_rd_ptr;

    assign out_empty = (out_wr_ptr == out_rd_ptr);
    assign out_full  = (out_wr_ptr[OAW] != out_rd_ptr[OAW]) &&
                       (out_wr_ptr[OAW-1:0] == out_rd_ptr[OAW-1:0]);
    assign out_valid = !out_empty;
    // Gate the head so the outputs read 0 while the FIFO is empty.
    assign out_data  = out_valid ? out_mem[out_rd_ptr[OAW-1:0]] : '0;
    assign out_node  = out_valid ? out_node_mem[out_rd_ptr[OAW-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
        end else begin
            if (drain_hit) begin
                out_mem[out_wr_ptr[OAW-1:0]]      <= pend_data[drain_idx];
                out_node_mem[out_wr_ptr[OAW-1:0]] <= drain_idx;
                out_wr_ptr                        <= out_wr_ptr + 1'b1;
            end
            if (out_valid && out_ready) begin
                out_rd_ptr <= out_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/can_packet_dispatcher.md
Name: can_packet_dispatcher

Overview:
- Synthesizable packet dispatcher/collector between the host-side packet stream and NUM_NODES CAN controller instances.
- Buffers incoming packets and hands them round-robin to requesting nodes, loading each node's programmed ID.
- Manages retransmit retries with priority escalation and drop, and drives receive-ID pairing.
- Collects received packets from all nodes into a single flow-controlled output stream with loss accounting.

Parameters:
- NUM_NODES, 4, number of CAN nodes served (even when PAIR_MODE=0).
- DATA_SIZE, 64, packet width in bits.
- ID_SIZE, 11, CAN identifier width.
- IN_DEPTH, 8, input FIFO depth (power of 2).
- OUT_DEPTH, 8, output FIFO depth (power of 2).
- MAX_RETRY, 3, retransmits allowed before a packet is dropped.
- PAIR_MODE, 0, 0: rx_id[i]=tx_id[i^1]; 1: ring, rx_id[i]=tx_id[(i+NUM_NODES-1)%NUM_NODES].

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_we  in  1  write ID table entry.
- cfg_idx  in  $clog2(NUM_NODES)  ID table index.
- cfg_id  in  ID_SIZE  ID value.
- in_valid / in_ready  in / out  1  input packet handshake.
- in_data  in  DATA_SIZE  input packet.
- data_in_req  in  NUM_NODES  node i requests a new packet.
- retransmit  in  NUM_NODES  node i reports a failed transmission.
- tx_valid  out  NUM_NODES  node i holds a loaded packet.
- tx_packet  out  NUM_NODES*DATA_SIZE  per-node packet, slice i.
- tx_id  out  NUM_NODES*ID_SIZE  per-node transmit ID.
- rx_id  out  NUM_NODES*ID_SIZE  per-node expected receive ID.
- data_out_req  in  NUM_NODES  node i presents a received packet.
- rx_packet  in  NUM_NODES*DATA_SIZE  per-node received packet.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  DATA_SIZE  collected packet.
- out_node  out  $clog2(NUM_NODES)  source node of out_data.
- lost_count  out  16  received packets overwritten before drain (saturating).
- drop_count  out  16  packets dropped after MAX_RETRY (saturating).

Behaviour:
- Reset effects:
  - All outputs are 0, except in_ready, which is 1.
  - Both FIFOs are emptied and the ID table is cleared to 0.
  - Retry counters, pending flags and both round-robin pointers are cleared to 0.
  - Any in-flight packets are discarded and are not counted in either counter.
- Input FIFO:
  - in_ready = !in_full; a push occurs on in_valid && in_ready.
  - There is no bypass: data pushed at edge t is first grantable at edge t+1.
  - Push and pop in the same cycle are legal.
- Grant:
  - Eligible node: data_in_req[i] && !retransmit[i].
  - Each cycle in which the FIFO is non-empty, the first eligible node at or after rr_in_ptr is granted and the FIFO is popped.
  - At most one grant per cycle; rr_in_ptr then moves to granted+1 (mod NUM_NODES).
  - On grant, registered at the edge:
    - tx_packet[i] <= FIFO head;
    - tx_id[i] <= id_table[i], using the pre-write value if cfg_we targets i in the same cycle;
    - tx_valid[i] <= 1; retry[i] <= 0.
  - Outputs are visible the cycle after the grant edge.
  - With the FIFO empty, requests remain pending; nodes hold data_in_req until granted.
- Retransmit (edge with retransmit[i] && tx_valid[i]):
  - If retry[i] < MAX_RETRY: retry[i]++ and tx_id[i] <= 0 (highest CAN priority); the packet is held.
  - Else: tx_valid[i] <= 0, retry[i] <= 0, drop_count++.
  - retransmit[i] while tx_valid[i]=0 is ignored.
  - retransmit[i] suppresses a same-cycle grant to node i.
- rx_id is combinational from the registered tx_id according to PAIR_MODE.
- Collection:
  - On data_out_req[i], pend_data[i] <= rx_packet[i] and pend[i] <= 1.
  - If pend[i] is already set and is not being drained that cycle, the old data is overwritten and lost_count++.
  - Each cycle with the output FIFO not full, the first pend[j] at or after rr_out_ptr moves to the output FIFO with out_node=j; pend[j] clears and rr_out_ptr <= j+1.
  - A same-cycle drain of j and a new data_out_req[j]: the new data is captured, pend stays 1, no loss is counted.
- Output FIFO:
  - out_valid = !empty; out_data and out_node come from the FIFO head.
  - The head pops on out_valid && out_ready.
  - When the FIFO is full, draining stalls and the pending registers absorb the backpressure.
- Counters: both saturate at 16'hFFFF.

Test Plan:
- Reset, then program IDs 0x101..0x104; push packets A, B; assert data_in_req=4'b0101 -> node0 gets A with tx_id 0x101 one cycle after grant; node2 gets B with 0x103 the next cycle; in_ready=1 throughout.
- MAX_RETRY=3: node1 loaded; pulse retransmit[1] three times -> tx_id[1]=0 and tx_valid[1]=1 after each; fourth pulse -> tx_valid[1]=0, drop_count=1.
- PAIR_MODE=0 with tx_ids {0x10,0x20,0x30,0x40} -> rx_id {0x20,0x10,0x40,0x30}; PAIR_MODE=1 -> rx_id {0x40,0x10,0x20,0x30}.
- Push IN_DEPTH packets with no requests -> in_ready=0; one grant -> in_ready=1 next cycle; data order preserved.
- out_ready=0, fill the output FIFO, then pulse data_out_req[3] twice -> lost_count=1; release out_ready -> the second rx_packet appears with out_node=3.
- All four data_out_req asserted in one cycle with out_ready=1 -> four outputs on consecutive cycles in node order 0,1,2,3; lost_count=0.
